lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: none; the data path is a fixed 32-bit word, little-endian.
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  1  core presents a load/store request.
REQ-005 req_ready  output  1  lsu accepts a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned (rs2).
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-012 resp_err  output  1  misaligned access or illegal funct3; valid with resp_valid.
REQ-013 mem_addr  output  32  word-aligned byte address {addr[31:2],2'b00}.
REQ-014 mem_r_enable  output  1  memory read strobe; data returns on mem_rdata one cycle later.
REQ-015 mem_w_enable  output  1  full-word memory write strobe.
REQ-016 mem_wdata  output  32  word to write.
REQ-017 mem_rdata  input  32  registered memory read data.

Function
REQ-018 FSM states SHALL be IDLE, READ, CAPT, WRITE, RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; a handshake (req_valid && req_ready) SHALL latch we/funct3/addr/wdata.
REQ-020 mem_r_enable and mem_w_enable SHALL never both be 1, and SHALL be 0 outside READ and WRITE respectively.
REQ-021 From IDLE on handshake: on error -> RESP; load or SB/SH -> READ; SW -> WRITE.
REQ-022 READ: mem_r_enable=1 for exactly one cycle -> CAPT.
REQ-023 CAPT, load: register the extracted lane into resp_rdata -> RESP. Lane = addr[1:0] for bytes, addr[1] for halves. LB/LH sign-extend; LBU/LHU zero-extend.
REQ-024 CAPT, SB/SH: merge store bytes into mem_rdata at the addressed lane, leaving other bytes unchanged; register the result as mem_wdata -> WRITE.
REQ-025 WRITE: mem_w_enable=1 for one cycle with mem_wdata -> RESP.
REQ-026 RESP: resp_valid=1 for one cycle -> IDLE. A new request is accepted no earlier than the following cycle.
REQ-027 Latency, handshake cycle to resp_valid:
- loads: 3 cycles
- SW: 2 cycles
- SB/SH: 4 cycles
- errors: 1 cycle
REQ-028 Error conditions:
- LH/LHU/SH with addr[0]=1
- LW/SW with addr[1:0]!=0
- load funct3 in {3,6,7}
- store funct3 >2
REQ-029 Errors SHALL issue no memory access and SHALL set resp_err=1, resp_rdata=0.
REQ-030 mem_addr SHALL hold the latched word address from READ through WRITE; otherwise it holds its last value.
REQ-031 req inputs SHALL be ignored outside IDLE; a dropped req_valid before the handshake has no effect.

Reset
REQ-032 rst_n=0 at a rising edge SHALL force IDLE and clear resp_valid, resp_err, resp_rdata, mem_wdata and mem_addr to 0.
REQ-033 mem_r_enable/mem_w_enable SHALL be 0 from the first cycle after reset.
REQ-034 A reset during READ/CAPT/WRITE SHALL abandon the operation: no write, no response.
REQ-035 req_ready SHALL be 1 in the first cycle after rst_n returns high.

Structure
REQ-036 The funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the lsu_state_t enum SHALL live in the shared package riscv_pkg.
REQ-037 Lane extraction, sign/zero extension and store merge SHALL be one combinational sub-module, lsu_align; all state and registers stay in lsu.

Verification
REQ-038 Memory word at 0x10 = 0x8004_03F2; LB addr 0x10 -> resp_rdata 0xFFFF_FFF2; LBU addr 0x11 -> 0x0000_0003; each with resp_valid 3 cycles after handshake.
REQ-039 Same word; LH addr 0x12 -> 0xFFFF_8004; LHU addr 0x12 -> 0x0000_8004; LW addr 0x10 -> 0x8004_03F2.
REQ-040 Word 0x20 = 0x1122_3344; SB addr 0x21 wdata 0xAB -> one read then one write of 0x1122_AB44, resp_valid at cycle 4; SH addr 0x22 wdata 0xBEEF -> 0xBEEF_AB44.
REQ-041 LW addr 0x13 and SH addr 0x05 -> resp_err=1, resp_rdata=0, no mem strobe, resp 1 cycle after handshake; load funct3=3 -> resp_err=1.
REQ-042 Reset asserted during WRITE of SB -> mem_w_enable 0 next cycle, memory unchanged, no resp_valid, req_ready=1 after release.
REQ-043 Back-to-back req_valid held high with SW then LW -> second handshake the cycle after the first resp_valid; strobes never overlap.

Source files
------------

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared RV32I definitions used by the load/store unit: the funct3 encodings
// for memory accesses, the LSU state enum and the access-legality check.
// No ports (package).
// -----------------------------------------------------------------------------
package riscv_pkg;

  // funct3 encodings shared by loads and stores (stores only use B/H/W).
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPT,
    WRITE,
    RESP
  } lsu_state_t;

  // 1 when the request is misaligned or uses a funct3 with no defined access.
  function automatic logic lsu_access_err(input logic       we,
                                          input logic [2:0] funct3,
                                          input logic [1:0] off);
    logic err;
    err = 1'b0;
    if (we) begin
      case (funct3)
        F3_B:    err = 1'b0;
        F3_H:    err = off[0];
        F3_W:    err = |off;
        default: err = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_BU: err = 1'b0;
        F3_H, F3_HU: err = off[0];
        F3_W:        err = |off;
        default:     err = 1'b1;
      endcase
    end
    return err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for the LSU.
//   funct3     in   access type (RV32I encoding)
//   off        in   byte offset within the word (addr[1:0])
//   rdata      in   word read from memory
//   wdata      in   right-aligned store data (only 16 bits can ever be merged)
//   load_data  out  extracted lane, sign/zero-extended to 32 bits
//   store_word out  rdata with the store bytes merged into the addressed lane
// -----------------------------------------------------------------------------
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statements leaves it unassigned (no latch).
    byte_lane  = 8'(rdata >> {off, 3'b000});
    half_lane  = off[1] ? rdata[31:16] : rdata[15:0];
    load_data  = '0;
    store_word = rdata;

    case (funct3)
      F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   load_data = {24'd0, byte_lane};
      F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
      F3_HU:   load_data = {16'd0, half_lane};
      F3_W:    load_data = rdata;
      default: load_data = '0;
    endcase

    // Read-modify-write merge for sub-word stores; untouched bytes keep rdata.
    case (funct3)
      F3_B: store_word[{off, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (off[1]) store_word[31:16] = wdata;
        else        store_word[15:0]  = wdata;
      end
      default: store_word = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu
// RV32I load/store unit in front of a word-wide memory with one-cycle
// registered read data. Sub-word stores are done as read-modify-write.
//   clk, rst_n                     clock, synchronous active-low reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_we, req_funct3, req_addr,
//   req_wdata                      request fields, latched on handshake
//   resp_valid                     one-cycle completion pulse
//   resp_rdata, resp_err           load result / error flag, valid with resp_valid
//   mem_addr                       word-aligned memory address
//   mem_r_enable, mem_w_enable     one-cycle read / full-word write strobes
//   mem_wdata, mem_rdata           memory write word / registered read word
// -----------------------------------------------------------------------------
module lsu
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_r_enable,
  output logic        mem_w_enable,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state, state_next;

  logic        handshake;
  logic        req_err;
  logic        req_is_sw;

  logic        op_we;
  logic [2:0]  op_funct3;
  logic [1:0]  op_off;
  logic [15:0] op_wdata;

  logic [31:0] load_data;
  logic [31:0] store_word;

  assign handshake = req_valid && req_ready;
  assign req_err   = lsu_access_err(req_we, req_funct3, req_addr[1:0]);
  assign req_is_sw = req_we && (req_funct3 == F3_W);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next state and strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_r_enable = 1'b0;
    mem_w_enable = 1'b0;

    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)        state_next = RESP;
          else if (req_is_sw) state_next = WRITE;
          else                state_next = READ;
        end
      end
      // Strobes are gated by rst_n so a reset landing on the strobe cycle
      // abandons the access at the memory as well, not only inside the LSU.
      READ: begin
        mem_r_enable = rst_n;
        state_next   = CAPT;
      end
      CAPT: begin
        state_next = op_we ? WRITE : RESP;
      end
      WRITE: begin
        mem_w_enable = rst_n;
        state_next   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request operands
  // ---------------------------------------------------------------------------
  // NOTE: these are pure data latches qualified by the handshake; nothing reads
  // them before a handshake has loaded them, so they carry no reset.
  always_ff @(posedge clk) begin
    if (handshake) begin
      op_we     <= req_we;
      op_funct3 <= req_funct3;
      op_off    <= req_addr[1:0];
      op_wdata  <= req_wdata[15:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Response and memory-side registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      if (handshake) begin
        // Stores and errors respond with zero data; loads overwrite in CAPT.
        resp_rdata <= '0;
        resp_err   <= req_err;
        if (!req_err) begin
          mem_addr <= {req_addr[31:2], 2'b00};
          if (req_is_sw) mem_wdata <= req_wdata;
        end
      end
      if (state == CAPT) begin
        if (op_we) mem_wdata  <= store_word;
        else       resp_rdata <= load_data;
      end
    end
  end

  lsu_align u_align (
    .funct3     (op_funct3),
    .off        (op_off),
    .rdata      (mem_rdata),
    .wdata      (op_wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu
// Self-checking bench for lsu: a word memory with one-cycle registered reads
// sits on the memory port, and a reference model computes each request's
// expected result, latency, memory traffic and resulting memory word.
// -----------------------------------------------------------------------------
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_r_enable;
  logic        mem_w_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_r_enable (mem_r_enable),
    .mem_w_enable (mem_w_enable),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // ---------------------------------------------------------------------------
  // Memory: 64 words, registered read data, preload port for the bench
  // ---------------------------------------------------------------------------
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en)        mem[pl_idx] <= pl_data;
    if (mem_r_enable) mem_rdata <= mem[mem_addr[7:2]];
    if (mem_w_enable) mem[mem_addr[7:2]] <= mem_wdata;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          rd;
    int          wr;
    logic [31:0] word;
  } exp_t;

  typedef struct {
    logic        ready;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          rd;
    int          wr;
    int          overlap;
    int          addr_bad;
    logic        pulse_ok;
  } obs_t;

  function automatic exp_t model(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] word);
    exp_t        e;
    bit          legal;
    int          size;
    int          off;
    int          sh;
    logic [31:0] mask;
    logic [31:0] v;
    off   = int'(addr % 4);
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f3[1:0];
    if (legal && (off % size) != 0) legal = 0;
    e.word  = word;
    e.rdata = '0;
    e.rd    = 0;
    e.wr    = 0;
    e.err   = 1'b0;
    if (!legal) begin
      e.err = 1'b1;
      e.lat = 1;
      return e;
    end
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    sh   = 8 * off;
    if (!we) begin
      v = (word >> sh) & mask;
      if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
      e.rdata = v;
      e.lat   = 3;
      e.rd    = 1;
    end else if (size == 4) begin
      e.word = wdata;
      e.lat  = 2;
      e.wr   = 1;
    end else begin
      e.word = (word & ~(mask << sh)) | ((wdata & mask) << sh);
      e.lat  = 4;
      e.rd   = 1;
      e.wr   = 1;
    end
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Drivers (observe only; comparisons live in the test tasks)
  // ---------------------------------------------------------------------------
  task automatic preload(input int idx, input logic [31:0] d);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_idx  = idx[5:0];
    pl_data = d;
    @(negedge clk);
    pl_en        = 1'b0;
    ref_mem[idx] = d;
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output obs_t o);
    int n;
    o = '{ready: 1'b0, lat: 0, rdata: '0, err: 1'b0, rd: 0, wr: 0,
          overlap: 0, addr_bad: 0, pulse_ok: 1'b0};
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    o.ready = req_ready;
    @(posedge clk);
    #1;
    // Scramble the request fields while busy; the LSU must ignore them.
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_r_enable) o.rd++;
      if (mem_w_enable) o.wr++;
      if (mem_r_enable && mem_w_enable) o.overlap++;
      if ((mem_r_enable || mem_w_enable) && mem_addr !== {addr[31:2], 2'b00}) o.addr_bad++;
      if (resp_valid) begin
        o.lat   = c;
        o.rdata = resp_rdata;
        o.err   = resp_err;
        break;
      end
    end
    if (o.lat > 0) begin
      @(negedge clk);
      o.pulse_ok = !resp_valid;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0)   begin fails++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (resp_err !== 1'b0)     begin fails++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
    checks++; if (resp_rdata !== 32'h0)  begin fails++; $display("FAIL reset_resp_rdata: got %h expected 0", resp_rdata); end
    checks++; if (mem_addr !== 32'h0)    begin fails++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0)   begin fails++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
    checks++; if ({mem_r_enable, mem_w_enable} !== 2'b00) begin fails++; $display("FAIL reset_strobes: got %b%b expected 00", mem_r_enable, mem_w_enable); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1)    begin fails++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [31:0] adrs [5] = '{32'h10, 32'h11, 32'h12, 32'h12, 32'h10};
    logic [31:0] exps [5] = '{32'hFFFF_FFF2, 32'h0000_0003, 32'hFFFF_8004, 32'h0000_8004, 32'h8004_03F2};
    obs_t o;
    preload(4, 32'h8004_03F2);
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, f3s[i], adrs[i], $urandom, o);
      checks++; if (o.rdata !== exps[i]) begin fails++; $display("FAIL load_rdata[%0d]: got %h expected %h", i, o.rdata, exps[i]); end
      checks++; if (o.lat != 3)          begin fails++; $display("FAIL load_latency[%0d]: got %0d expected 3", i, o.lat); end
      checks++; if (o.err !== 1'b0)      begin fails++; $display("FAIL load_err[%0d]: got %b expected 0", i, o.err); end
      checks++; if (o.rd != 1 || o.wr != 0) begin fails++; $display("FAIL load_strobes[%0d]: got rd=%0d wr=%0d expected rd=1 wr=0", i, o.rd, o.wr); end
      checks++; if (o.addr_bad != 0 || !o.pulse_ok) begin fails++; $display("FAIL load_addr_pulse[%0d]: got addr_bad=%0d pulse_ok=%b expected 0/1", i, o.addr_bad, o.pulse_ok); end
    end
    checks++; if (mem[4] !== 32'h8004_03F2) begin fails++; $display("FAIL load_mem_unchanged: got %h expected 800403f2", mem[4]); end
  endtask

  task automatic test_stores();
    obs_t o;
    preload(8, 32'h1122_3344);
    do_req(1'b1, 3'd0, 32'h21, 32'h0000_00AB, o);
    checks++; if (mem[8] !== 32'h1122_AB44) begin fails++; $display("FAIL sb_mem: got %h expected 1122ab44", mem[8]); end
    checks++; if (o.lat != 4)               begin fails++; $display("FAIL sb_latency: got %0d expected 4", o.lat); end
    checks++; if (o.rd != 1 || o.wr != 1 || o.overlap != 0) begin fails++; $display("FAIL sb_strobes: got rd=%0d wr=%0d ov=%0d expected 1/1/0", o.rd, o.wr, o.overlap); end
    checks++; if (o.rdata !== 32'h0 || o.err !== 1'b0) begin fails++; $display("FAIL sb_resp: got rdata=%h err=%b expected 0/0", o.rdata, o.err); end
    do_req(1'b1, 3'd1, 32'h22, 32'h1234_BEEF, o);
    checks++; if (mem[8] !== 32'hBEEF_AB44) begin fails++; $display("FAIL sh_mem: got %h expected beefab44", mem[8]); end
    checks++; if (o.lat != 4 || o.addr_bad != 0) begin fails++; $display("FAIL sh_latency: got lat=%0d addr_bad=%0d expected 4/0", o.lat, o.addr_bad); end
    do_req(1'b1, 3'd2, 32'h24, 32'hCAFE_F00D, o);
    checks++; if (mem[9] !== 32'hCAFE_F00D) begin fails++; $display("FAIL sw_mem: got %h expected cafef00d", mem[9]); end
    checks++; if (o.lat != 2 || o.rd != 0 || o.wr != 1) begin fails++; $display("FAIL sw_timing: got lat=%0d rd=%0d wr=%0d expected 2/0/1", o.lat, o.rd, o.wr); end
    ref_mem[8] = 32'hBEEF_AB44;
    ref_mem[9] = 32'hCAFE_F00D;
  endtask

  task automatic test_errors();
    logic        wes  [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s  [3] = '{3'd2, 3'd1, 3'd3};
    logic [31:0] adrs [3] = '{32'h13, 32'h05, 32'h10};
    obs_t o;
    for (int i = 0; i < 3; i++) begin
      do_req(wes[i], f3s[i], adrs[i], 32'hFFFF_FFFF, o);
      checks++; if (o.err !== 1'b1)     begin fails++; $display("FAIL err_flag[%0d]: got %b expected 1", i, o.err); end
      checks++; if (o.rdata !== 32'h0)  begin fails++; $display("FAIL err_rdata[%0d]: got %h expected 0", i, o.rdata); end
      checks++; if (o.lat != 1)         begin fails++; $display("FAIL err_latency[%0d]: got %0d expected 1", i, o.lat); end
      checks++; if (o.rd != 0 || o.wr != 0) begin fails++; $display("FAIL err_strobes[%0d]: got rd=%0d wr=%0d expected 0/0", i, o.rd, o.wr); end
    end
    checks++; if (mem[1] !== ref_mem[1]) begin fails++; $display("FAIL err_mem_unchanged: got %h expected %h", mem[1], ref_mem[1]); end
  endtask

  task automatic test_back_to_back();
    int first_resp = -1;
    int second_hs  = -1;
    int lw_resp    = -1;
    int overlap    = 0;
    int rd         = 0;
    int wr         = 0;
    logic [31:0] lw_data = '0;
    preload(12, 32'h0BAD_0BAD);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h30;
    req_wdata  = 32'h5A5A_C3C3;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_r_enable && mem_w_enable) overlap++;
      if (mem_r_enable) rd++;
      if (mem_w_enable) wr++;
      if (resp_valid && first_resp < 0) begin
        first_resp = k;
        req_we     = 1'b0;
        req_wdata  = '0;
      end else if (resp_valid) begin
        lw_resp = k;
        lw_data = resp_rdata;
        break;
      end
      if (req_valid && req_ready && first_resp >= 0 && second_hs < 0) begin
        second_hs = k;
        @(posedge clk);
        #1 req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checks++; if (first_resp != 2) begin fails++; $display("FAIL b2b_sw_resp: got cycle %0d expected 2", first_resp); end
    checks++; if (second_hs != 3)  begin fails++; $display("FAIL b2b_second_handshake: got cycle %0d expected 3", second_hs); end
    checks++; if (lw_resp != 6)    begin fails++; $display("FAIL b2b_lw_resp: got cycle %0d expected 6", lw_resp); end
    checks++; if (lw_data !== 32'h5A5A_C3C3) begin fails++; $display("FAIL b2b_lw_data: got %h expected 5a5ac3c3", lw_data); end
    checks++; if (overlap != 0 || rd != 1 || wr != 1) begin fails++; $display("FAIL b2b_strobes: got ov=%0d rd=%0d wr=%0d expected 0/1/1", overlap, rd, wr); end
    ref_mem[12] = 32'h5A5A_C3C3;
  endtask

  task automatic test_reset_during_write();
    int wk   = -1;
    int seen = 0;
    preload(8, 32'h1122_3344);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd0;
    req_addr   = 32'h21;
    req_wdata  = 32'h0000_00AB;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (mem_w_enable) begin
        wk    = k;
        rst_n = 1'b0;
        break;
      end
    end
    checks++; if (wk != 3) begin fails++; $display("FAIL rstw_write_cycle: got %0d expected 3", wk); end
    @(negedge clk);
    checks++; if (mem_w_enable !== 1'b0 || resp_valid !== 1'b0) begin fails++; $display("FAIL rstw_outputs: got w=%b resp=%b expected 0/0", mem_w_enable, resp_valid); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin fails++; $display("FAIL rstw_regs: got addr=%h wdata=%h expected 0/0", mem_addr, mem_wdata); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rstw_req_ready: got %b expected 1", req_ready); end
    repeat (4) begin
      @(negedge clk);
      if (resp_valid || mem_r_enable || mem_w_enable) seen++;
    end
    checks++; if (seen != 0) begin fails++; $display("FAIL rstw_no_activity: got %0d active cycles expected 0", seen); end
    checks++; if (mem[8] !== 32'h1122_3344) begin fails++; $display("FAIL rstw_mem: got %h expected 11223344", mem[8]); end
  endtask

  task automatic test_random();
    obs_t        o;
    exp_t        e;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          idx;
    for (int i = 0; i < 80; i++) begin
      we    = 1'($urandom);
      f3    = we ? 3'($urandom_range(0, 3)) : 3'($urandom);
      addr  = $urandom_range(0, 255);
      wdata = $urandom;
      idx   = int'(addr[7:2]);
      e     = model(we, f3, addr, wdata, ref_mem[idx]);
      do_req(we, f3, addr, wdata, o);
      checks++; if (o.err !== e.err || o.rdata !== e.rdata) begin fails++; $display("FAIL rand_resp[%0d] we=%b f3=%0d a=%h: got err=%b rdata=%h expected err=%b rdata=%h", i, we, f3, addr, o.err, o.rdata, e.err, e.rdata); end
      checks++; if (o.lat != e.lat || !o.ready || !o.pulse_ok) begin fails++; $display("FAIL rand_timing[%0d]: got lat=%0d ready=%b pulse=%b expected lat=%0d", i, o.lat, o.ready, o.pulse_ok, e.lat); end
      checks++; if (o.rd != e.rd || o.wr != e.wr || o.overlap != 0 || o.addr_bad != 0) begin fails++; $display("FAIL rand_strobes[%0d]: got rd=%0d wr=%0d ov=%0d ab=%0d expected rd=%0d wr=%0d", i, o.rd, o.wr, o.overlap, o.addr_bad, e.rd, e.wr); end
      checks++; if (mem[idx] !== e.word) begin fails++; $display("FAIL rand_mem[%0d] idx=%0d: got %h expected %h", i, idx, mem[idx], e.word); end
      ref_mem[idx] = e.word;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    test_loads();
    test_stores();
    test_errors();
    test_back_to_back();
    test_reset_during_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
